// File: rtl/ddr_frame_writer.sv
// ddr_frame_writer
//   Packs 8 RGB888 pixels into one 256-bit word, queues the words in a small
//   FIFO and writes them as single-beat DDR writes into two ping-pong frame
//   buffers. The buffer holding the newest complete frame is published on
//   rd_frame_sel so the read side always sees a whole frame.
//
// Ports (all logic on the rising edge of ddr_clk, rst synchronous active-high)
//   ddr_clk       in   write-side DDR controller clock
//   rst           in   synchronous reset
//   init_done     in   DDR / video front-end initialisation complete
//   frame_start   in   one-cycle start-of-frame pulse (input VS)
//   pix_valid     in   pixel valid
//   pix_data      in   {R,G,B}
//   pix_ready     out  pixel accepted when pix_valid && pix_ready
//   wr_req        out  one-cycle write request
//   wr_addr       out  write address, held until wr_done
//   wr_data       out  write data, held until wr_done
//   awlen         out  burst length-1, always single beat
//   wr_busy       in   write channel busy, only looked at while idle
//   wr_done       in   one-cycle pulse, outstanding write completed
//   frame_done    out  one-cycle pulse, last word of a frame written
//   rd_frame_sel  out  0 = FB0, 1 = FB1, newest complete frame
//   frame_cnt     out  completed frame count, wraps
//
// Write FSM
//   state  | meaning
//   S_IDLE | no write outstanding; issues the FIFO head when allowed
//   S_WAIT | write issued, address/data held until wr_done

module ddr_frame_writer #(
    parameter int                ADDR_W      = 28,
    parameter int                DATA_W      = 256,
    parameter int                FRAME_BEATS = 259200,
    parameter logic [ADDR_W-1:0] FB0_BASE    = 28'h0000000,
    parameter logic [ADDR_W-1:0] FB1_BASE    = 28'h0800000,
    parameter int                BUF_DEPTH   = 16
) (
    input  logic              ddr_clk,
    input  logic              rst,
    input  logic              init_done,
    input  logic              frame_start,
    input  logic              pix_valid,
    input  logic [23:0]       pix_data,
    output logic              pix_ready,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [3:0]        awlen,
    input  logic              wr_busy,
    input  logic              wr_done,
    output logic              frame_done,
    output logic              rd_frame_sel,
    output logic [15:0]       frame_cnt
);

    localparam int                PTR_W       = $clog2(BUF_DEPTH);
    localparam int                LAST_OFF_I  = (FRAME_BEATS - 1) * 32;
    localparam logic [ADDR_W-1:0] LAST_OFFSET = LAST_OFF_I[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] BEAT_STEP   = ADDR_W'(32);
    localparam logic [PTR_W:0]    FIFO_FULL   = BUF_DEPTH[PTR_W:0];

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t              state, state_nxt;
    logic                issue, pop;

    logic [2:0]          pack_cnt;
    logic [7*32-1:0]     pack_word;
    logic [DATA_W-1:0]   full_word;

    logic [DATA_W-1:0]   fifo_mem [BUF_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [PTR_W:0]      fifo_cnt;

    logic [ADDR_W-1:0]   offset;
    logic                wr_sel;
    logic                restart_pend;

    logic                pix_fire, push;
    logic                fs_now, fs_defer, restart_clear;
    logic                last_beat;

    // pix_ready is forced low while rst is held so every output sits at its
    // reset value during reset.
    assign pix_ready = !rst && init_done && !restart_pend &&
                       (pack_cnt != 3'd7 || fifo_cnt < FIFO_FULL);
    assign pix_fire  = pix_valid && pix_ready;

    // Start of frame takes effect at once only when nothing of the old frame
    // is left anywhere; otherwise the partial word is dropped and the queued
    // words drain before the offset is rewound.
    assign fs_now        = frame_start && !restart_pend && fifo_cnt == '0 &&
                           pack_cnt == 3'd0 && state == S_IDLE && !issue;
    assign fs_defer      = frame_start && !restart_pend && !fs_now;
    assign restart_clear = restart_pend && fifo_cnt == '0 && state == S_IDLE;

    // A pixel arriving together with a deferred frame_start belongs to the
    // discarded partial word, so it never completes a word.
    assign push      = pix_fire && pack_cnt == 3'd7 && !fs_defer;
    assign full_word = {8'h00, pix_data, pack_word};
    assign last_beat = (offset == LAST_OFFSET);
    assign awlen     = 4'd0;

    always_ff @(posedge ddr_clk) begin
        if (rst) begin
            pack_cnt  <= '0;
            pack_word <= '0;
        end else if (fs_defer) begin
            pack_cnt  <= '0;
        end else if (pix_fire) begin
            if (pack_cnt != 3'd7) begin
                pack_word[{pack_cnt, 5'd0} +: 32] <= {8'h00, pix_data};
            end
            pack_cnt <= pack_cnt + 3'd1;
        end
    end

    always_ff @(posedge ddr_clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= full_word;
        end
    end

    always_ff @(posedge ddr_clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (PTR_W + 1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (PTR_W + 1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge ddr_clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (init_done && fifo_cnt != '0 && !wr_busy) begin
                    issue     = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wr_done) begin
                    pop       = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ddr_clk) begin
        if (rst) begin
            wr_req       <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            offset       <= '0;
            wr_sel       <= 1'b0;
            rd_frame_sel <= 1'b1;
            frame_done   <= 1'b0;
            frame_cnt    <= '0;
            restart_pend <= 1'b0;
        end else begin
            wr_req     <= issue;
            frame_done <= 1'b0;
            if (issue) begin
                wr_addr <= (wr_sel ? FB1_BASE : FB0_BASE) + offset;
                wr_data <= fifo_mem[rd_ptr];
            end
            if (pop) begin
                if (last_beat) begin
                    offset       <= '0;
                    rd_frame_sel <= wr_sel;
                    wr_sel       <= ~wr_sel;
                    frame_done   <= 1'b1;
                    frame_cnt    <= frame_cnt + 16'd1;
                end else begin
                    offset <= offset + BEAT_STEP;
                end
            end else if (fs_now || restart_clear) begin
                offset <= '0;
            end
            if (fs_defer) begin
                restart_pend <= 1'b1;
            end else if (restart_clear) begin
                restart_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ddr_frame_writer.sv
module tb_ddr_frame_writer;

    localparam logic [27:0] FB0 = 28'h0000000;
    localparam logic [27:0] FB1 = 28'h0800000;

    logic         ddr_clk = 1'b0;
    logic         rst, init_done, frame_start, pix_valid, pix_ready;
    logic [23:0]  pix_data;
    logic         wr_req, wr_busy, wr_done, frame_done, rd_frame_sel;
    logic [27:0]  wr_addr;
    logic [255:0] wr_data;
    logic [3:0]   awlen;
    logic [15:0]  frame_cnt;

    int total = 0;
    int bad = 0;
    int writes_done = 0;
    int fdone_seen = 0;
    logic resp_en = 1'b0;
    int resp_delay = 5;
    logic [27:0]  cap_addr_q [$];
    logic [255:0] cap_data_q [$];

    typedef struct {
        logic [23:0] pix_base;
        logic [27:0] exp_addr;
        logic        exp_fdone;
        logic        exp_rd_sel;
        logic [15:0] exp_fcnt;
    } vec_t;
    vec_t vecs [6];

    ddr_frame_writer #(
        .ADDR_W(28), .DATA_W(256), .FRAME_BEATS(4),
        .FB0_BASE(28'h0000000), .FB1_BASE(28'h0800000), .BUF_DEPTH(16)
    ) dut (
        .ddr_clk(ddr_clk), .rst(rst), .init_done(init_done), .frame_start(frame_start),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .awlen(awlen),
        .wr_busy(wr_busy), .wr_done(wr_done), .frame_done(frame_done),
        .rd_frame_sel(rd_frame_sel), .frame_cnt(frame_cnt)
    );

    always #5 ddr_clk = ~ddr_clk;

    task automatic tick();
        @(posedge ddr_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [255:0] pack8(input logic [23:0] b);
        logic [255:0] w;
        w = '0;
        for (int k = 0; k < 8; k++) w[32*k +: 32] = {8'h00, b + 24'(k)};
        return w;
    endfunction

    task automatic send_pix(input logic [23:0] d);
        int g;
        g = 0;
        pix_valid = 1'b1;
        pix_data  = d;
        while (!pix_ready && g < 1000) begin
            tick();
            g++;
        end
        if (!pix_ready) begin
            total++;
            bad++;
            $display("FAIL send_pix timeout: pix_ready %0b expected 1", pix_ready);
        end
        tick();
        pix_valid = 1'b0;
    endtask

    task automatic send8(input logic [23:0] base);
        for (int i = 0; i < 8; i++) send_pix(base + 24'(i));
    endtask

    task automatic wait_writes(input int target, input string name);
        int g;
        g = 0;
        while (writes_done < target && g < 3000) begin
            tick();
            g++;
        end
        chk_int({name, "_writes"}, writes_done, target);
        repeat (3) tick();
    endtask

    task automatic check_write(input string name, input logic [27:0] ea, input logic [255:0] ed);
        logic [27:0]  a;
        logic [255:0] d;
        if (cap_addr_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: got no write expected addr %0h", name, ea);
        end else begin
            a = cap_addr_q.pop_front();
            d = cap_data_q.pop_front();
            chk({name, "_addr"}, 256'(a), 256'(ea));
            chk({name, "_data"}, d, ed);
        end
    endtask

    // Write-channel responder: answers each wr_req with wr_done after
    // resp_delay cycles while resp_en is set, and records every request.
    initial begin
        logic [27:0]  h_addr;
        logic [255:0] h_data;
        logic         outstanding;
        int           cnt;
        outstanding = 1'b0;
        cnt = 0;
        h_addr = '0;
        h_data = '0;
        wr_done = 1'b0;
        forever begin
            tick();
            wr_done = 1'b0;
            if (frame_done) fdone_seen++;
            if (rst) begin
                outstanding = 1'b0;
                cnt = 0;
            end else if (wr_req) begin
                outstanding = 1'b1;
                cnt = resp_delay;
                h_addr = wr_addr;
                h_data = wr_data;
                cap_addr_q.push_back(wr_addr);
                cap_data_q.push_back(wr_data);
            end else if (outstanding && resp_en) begin
                if (cnt > 0) cnt--;
                if (cnt == 0) begin
                    chk("wr_addr_hold", 256'(wr_addr), 256'(h_addr));
                    chk("wr_data_hold", wr_data, h_data);
                    wr_done = 1'b1;
                    outstanding = 1'b0;
                    writes_done++;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time %0t expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int f0, acc, nreq;
        logic rdy;
        logic [27:0] m_off;
        logic m_sel;

        vecs[0] = '{24'h000001, 28'h0000000, 1'b0, 1'b1, 16'd0};
        vecs[1] = '{24'h000009, 28'h0000020, 1'b0, 1'b1, 16'd0};
        vecs[2] = '{24'h000011, 28'h0000040, 1'b0, 1'b1, 16'd0};
        vecs[3] = '{24'h000019, 28'h0000060, 1'b1, 1'b0, 16'd1};
        vecs[4] = '{24'h000021, 28'h0800000, 1'b0, 1'b0, 16'd1};
        vecs[5] = '{24'h000029, 28'h0800020, 1'b0, 1'b0, 16'd1};

        rst = 1'b1; init_done = 1'b0; frame_start = 1'b0;
        pix_valid = 1'b0; pix_data = '0; wr_busy = 1'b0;
        repeat (3) tick();
        chk("rst_wr_req",     256'(wr_req),       256'(0));
        chk("rst_wr_addr",    256'(wr_addr),      256'(0));
        chk("rst_wr_data",    wr_data,            256'(0));
        chk("rst_awlen",      256'(awlen),        256'(0));
        chk("rst_frame_done", 256'(frame_done),   256'(0));
        chk("rst_rd_sel",     256'(rd_frame_sel), 256'(1));
        chk("rst_frame_cnt",  256'(frame_cnt),    256'(0));
        chk("rst_pix_ready",  256'(pix_ready),    256'(0));
        rst = 1'b0;
        tick();
        chk("init_low_pix_ready", 256'(pix_ready), 256'(0));
        init_done = 1'b1;
        tick();
        chk("init_high_pix_ready", 256'(pix_ready), 256'(1));
        resp_en = 1'b1;

        // Single words through a 4-beat frame and into the other buffer.
        for (int i = 0; i < 6; i++) begin
            f0 = fdone_seen;
            send8(vecs[i].pix_base);
            wait_writes(i + 1, $sformatf("tbl%0d", i));
            check_write($sformatf("tbl%0d", i), vecs[i].exp_addr, pack8(vecs[i].pix_base));
            chk_int($sformatf("tbl%0d_frame_done", i), fdone_seen - f0, int'(vecs[i].exp_fdone));
            chk($sformatf("tbl%0d_rd_sel", i), 256'(rd_frame_sel), 256'(vecs[i].exp_rd_sel));
            chk($sformatf("tbl%0d_frame_cnt", i), 256'(frame_cnt), 256'(vecs[i].exp_fcnt));
        end

        // Backpressure: no wr_done, continuous pixels until the FIFO is full.
        resp_en = 1'b0;
        acc = 0;
        pix_valid = 1'b1;
        for (int c = 0; c < 300; c++) begin
            pix_data = 24'(49 + acc);
            rdy = pix_ready;
            tick();
            if (rdy) acc++;
        end
        pix_valid = 1'b0;
        chk_int("fill_accepted", acc, 16 * 8 + 7);
        chk("fill_pix_ready", 256'(pix_ready), 256'(0));
        resp_en = 1'b1;
        wait_writes(6 + 16, "fill_drain");
        chk("fill_pix_ready_back", 256'(pix_ready), 256'(1));
        send_pix(24'(49 + acc));
        wait_writes(6 + 17, "fill_last");
        chk_int("fill_q_size", cap_addr_q.size(), 17);
        m_sel = 1'b1;
        m_off = 28'd64;
        for (int j = 0; j < 17; j++) begin
            check_write($sformatf("fill_w%0d", j), (m_sel ? FB1 : FB0) + m_off, pack8(24'(49 + 8 * j)));
            m_off = m_off + 28'd32;
            if (m_off == 28'd128) begin
                m_off = '0;
                m_sel = ~m_sel;
            end
        end
        chk("fill_frame_cnt", 256'(frame_cnt), 256'(5));
        chk("fill_rd_sel", 256'(rd_frame_sel), 256'(0));

        // Immediate restart while idle and empty, then a deferred restart
        // with two words queued and three pixels in the packer.
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        resp_en = 1'b0;
        f0 = fdone_seen;
        send8(24'h100000);
        send8(24'h100008);
        for (int i = 0; i < 3; i++) send_pix(24'h100010 + 24'(i));
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("restart_pix_ready", 256'(pix_ready), 256'(0));
        resp_en = 1'b1;
        wait_writes(25, "restart_drain");
        chk("restart_pix_ready_back", 256'(pix_ready), 256'(1));
        send8(24'h200000);
        wait_writes(26, "restart_new");
        check_write("restart_w0", FB1 + 28'd0, pack8(24'h100000));
        check_write("restart_w1", FB1 + 28'd32, pack8(24'h100008));
        check_write("restart_w2", FB1 + 28'd0, pack8(24'h200000));
        chk_int("restart_no_frame_done", fdone_seen - f0, 0);
        chk("restart_frame_cnt", 256'(frame_cnt), 256'(5));
        chk("restart_rd_sel", 256'(rd_frame_sel), 256'(0));

        // wr_busy holds off the request; it follows one cycle after release.
        wr_busy = 1'b1;
        send8(24'h300000);
        nreq = 0;
        repeat (20) begin
            tick();
            if (wr_req) nreq++;
        end
        chk_int("busy_no_req", nreq, 0);
        wr_busy = 1'b0;
        chk("busy_req_not_yet", 256'(wr_req), 256'(0));
        tick();
        chk("busy_req_after", 256'(wr_req), 256'(1));
        wait_writes(27, "busy");
        check_write("busy_w", FB1 + 28'd32, pack8(24'h300000));

        // Reset while a write is outstanding.
        resp_en = 1'b0;
        send8(24'h400000);
        repeat (3) tick();
        check_write("rst_inflight", FB1 + 28'd64, pack8(24'h400000));
        rst = 1'b1;
        tick();
        chk("rst2_wr_req",     256'(wr_req),       256'(0));
        chk("rst2_wr_addr",    256'(wr_addr),      256'(0));
        chk("rst2_wr_data",    wr_data,            256'(0));
        chk("rst2_frame_done", 256'(frame_done),   256'(0));
        chk("rst2_rd_sel",     256'(rd_frame_sel), 256'(1));
        chk("rst2_frame_cnt",  256'(frame_cnt),    256'(0));
        chk("rst2_pix_ready",  256'(pix_ready),    256'(0));
        tick();
        rst = 1'b0;
        tick();
        resp_en = 1'b1;
        send8(24'h500000);
        wait_writes(28, "rst_fresh");
        check_write("rst_fresh", FB0 + 28'd0, pack8(24'h500000));
        chk("rst_fresh_frame_cnt", 256'(frame_cnt), 256'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
